// File: rtl/write_buffered.sv
// Write-back stage with a posted DEPTH-entry store queue draining to the memory port.
// Optional macro WRITE_BUFFERED_COMBINE_EN merges a store into the newest queued entry on address match.
module write_buffered #(
  parameter int unsigned W         = 32,
  parameter int unsigned NR        = 32,
  parameter int unsigned PC_IDX    = NR - 1,
  parameter int unsigned FLAGS_IDX = NR - 2,
  parameter int unsigned FLAG_BITS = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    is_valid,
  output logic                    hold,
  input  logic [$clog2(NR)-1:0]   destination_register,
  input  logic [W-1:0]            destination_value,
  input  logic                    has_upper_value,
  input  logic [W-1:0]            upper_value,
  input  logic                    is_writing_memory,
  input  logic [W-1:0]            adjustment_value,
  input  logic [FLAG_BITS-1:0]    flags,
  input  logic [W-1:0]            pc,
  input  logic [W-1:0]            next_pc,
  input  logic                    has_flushed_in,
  output logic                    has_flushed_out,
  input  logic [NR*W-1:0]         input_registers,
  output logic [NR*W-1:0]         output_registers,
  output logic                    address_enable,
  output logic [W-1:0]            address,
  output logic [W-1:0]            data,
  input  logic                    data_valid,
  output logic                    sq_empty,
  output logic                    fb_valid,
  output logic [$clog2(NR)-1:0]   fb_index,
  output logic [W-1:0]            fb_value,
  output logic [W-1:0]            fb_upper_value,
  output logic                    fb_has_upper
);

  localparam int unsigned IDX_W = $clog2(NR);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] PC_SEL   = IDX_W'(PC_IDX);
  localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NR - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } sq_entry_t;

  sq_entry_t        sq_mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [NR*W-1:0]  regs_q;
  logic             has_flushed_q;

  logic [W-1:0]     regs_in [NR];
  logic [W-1:0]     regs_d  [NR];
  logic [IDX_W-1:0] upper_idx;
  logic [W-1:0]     base;
  logic [W-1:0]     store_addr;
  logic             full;
  logic             pop;
  logic             accept;
  logic             push;
  logic             combine;

  assign sq_empty       = (count_q == '0);
  assign full           = (count_q == FULL_CNT);
  assign address_enable = !sq_empty;
  assign pop            = data_valid && address_enable;
  assign address        = sq_mem[head_q].addr;
  assign data           = sq_mem[head_q].data;

`ifdef WRITE_BUFFERED_COMBINE_EN
  logic [PTR_W-1:0] tail_prev;
  assign tail_prev = tail_q - PTR_W'(1);
  // The newest entry is off limits only while it is the head being accepted this cycle.
  assign combine = is_valid && is_writing_memory && !sq_empty
                   && (sq_mem[tail_prev].addr == store_addr)
                   && !(pop && (count_q == CNT_W'(1)));
`else
  assign combine = 1'b0;
`endif

  assign hold   = reset_n && is_valid && is_writing_memory && full && !pop && !combine;
  assign accept = is_valid && !hold;
  assign push   = accept && is_writing_memory && !combine;

  assign fb_valid       = is_valid && !is_writing_memory;
  assign fb_index       = destination_register;
  assign fb_value       = destination_value;
  assign fb_upper_value = upper_value;
  assign fb_has_upper   = has_upper_value;

  assign output_registers = regs_q;
  assign has_flushed_out  = has_flushed_q;

  // Unpack the flattened register file.
  always_comb begin
    for (int i = 0; i < int'(NR); i++) begin
      regs_in[i] = input_registers[i*W +: W];
    end
  end

  // Store address base sees the live PC and a hard-wired zero register.
  always_comb begin
    base = regs_in[destination_register];
    if (destination_register == PC_SEL) begin
      base = pc;
    end else if (destination_register == '0) begin
      base = '0;
    end
    store_addr = base + adjustment_value;
  end

  // Next register file: flags merge, result writes, then PC and r0 overrides.
  always_comb begin
    for (int i = 0; i < int'(NR); i++) begin
      regs_d[i] = regs_in[i];
    end
    upper_idx = (destination_register == LAST_SEL) ? '0 : destination_register + IDX_W'(1);
    if (accept) begin
      regs_d[FLAGS_IDX][W-2 -: FLAG_BITS] = flags;
      if (!is_writing_memory) begin
        regs_d[destination_register] = destination_value;
        if (has_upper_value && (upper_idx != '0)) begin
          regs_d[upper_idx] = upper_value;
        end
      end
    end
    if (accept && !is_writing_memory && (destination_register == PC_SEL)) begin
      regs_d[PC_IDX] = destination_value;
    end else begin
      regs_d[PC_IDX] = next_pc;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q        <= '0;
      has_flushed_q <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      for (int i = 0; i < int'(NR); i++) begin
        regs_q[i*W +: W] <= regs_d[i];
      end
      has_flushed_q <= accept ? has_flushed_in : 1'b0;
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue payload needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      sq_mem[tail_q] <= '{addr: store_addr, data: destination_value};
    end
`ifdef WRITE_BUFFERED_COMBINE_EN
    else if (combine) begin
      sq_mem[tail_prev].data <= destination_value;
    end
`endif
  end

endmodule

// File: tb/tb_write_buffered.sv
// Directed bench for write_buffered: register commit checks plus a store scoreboard.
module tb_write_buffered;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] d;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            is_valid;
  logic            hold;
  logic [4:0]      destination_register;
  logic [W-1:0]    destination_value;
  logic            has_upper_value;
  logic [W-1:0]    upper_value;
  logic            is_writing_memory;
  logic [W-1:0]    adjustment_value;
  logic [3:0]      flags;
  logic [W-1:0]    pc;
  logic [W-1:0]    next_pc;
  logic            has_flushed_in;
  logic            has_flushed_out;
  logic [NR*W-1:0] input_registers;
  logic [NR*W-1:0] output_registers;
  logic            address_enable;
  logic [W-1:0]    address;
  logic [W-1:0]    data;
  logic            data_valid;
  logic            sq_empty;
  logic            fb_valid;
  logic [4:0]      fb_index;
  logic [W-1:0]    fb_value;
  logic [W-1:0]    fb_upper_value;
  logic            fb_has_upper;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clock = ~clock;

  assign input_registers = output_registers;

  write_buffered dut (
    .clock(clock), .reset_n(reset_n), .is_valid(is_valid), .hold(hold),
    .destination_register(destination_register), .destination_value(destination_value),
    .has_upper_value(has_upper_value), .upper_value(upper_value),
    .is_writing_memory(is_writing_memory), .adjustment_value(adjustment_value),
    .flags(flags), .pc(pc), .next_pc(next_pc),
    .has_flushed_in(has_flushed_in), .has_flushed_out(has_flushed_out),
    .input_registers(input_registers), .output_registers(output_registers),
    .address_enable(address_enable), .address(address), .data(data),
    .data_valid(data_valid), .sq_empty(sq_empty),
    .fb_valid(fb_valid), .fb_index(fb_index), .fb_value(fb_value),
    .fb_upper_value(fb_upper_value), .fb_has_upper(fb_has_upper)
  );

  function automatic logic [W-1:0] rv(input int i);
    return output_registers[i*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    is_valid = 1'b0; is_writing_memory = 1'b0; has_upper_value = 1'b0;
    flags = '0; has_flushed_in = 1'b0; destination_register = '0;
    destination_value = '0; upper_value = '0; adjustment_value = '0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [W-1:0] v, input logic up,
                     input logic [W-1:0] upv, input logic [W-1:0] npc);
    clr();
    is_valid = 1'b1; destination_register = r; destination_value = v;
    has_upper_value = up; upper_value = upv; next_pc = npc; pc = npc - 32'd4;
  endtask

  task automatic st(input logic [4:0] r, input logic [W-1:0] adj, input logic [W-1:0] v,
                    input logic [3:0] fl);
    clr();
    is_valid = 1'b1; is_writing_memory = 1'b1; destination_register = r;
    adjustment_value = adj; destination_value = v; flags = fl;
  endtask

  // Memory accepts the head entry for one cycle; compared against the oldest expected store.
  task automatic take(input string tag);
    chk({tag, "_ae"}, {31'b0, address_enable}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, address, e.a);
      chk({tag, "_data"}, data, e.d);
    end
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    data_valid = 1'b0; pc = '0; next_pc = '0; reset_n = 1'b0;
    tick(); tick();
    checks++;
    assert (output_registers === '0) else begin
      errors++;
      $error("FAIL reset_regs observed=%0h expected=0", output_registers[W-1:0]);
    end
    chk("reset_empty", {31'b0, sq_empty}, 32'd1);
    chk("reset_ae", {31'b0, address_enable}, 32'd0);
    chk("reset_hold", {31'b0, hold}, 32'd0);
    chk("reset_flush", {31'b0, has_flushed_out}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU commits
    alu(5'd5, 32'h11, 1'b0, '0, 32'h104);
    #1;
    chk("fb_valid", {31'b0, fb_valid}, 32'd1);
    chk("fb_index", {27'b0, fb_index}, 32'd5);
    tick();
    chk("r5", rv(5), 32'h11);
    chk("pc_seq0", rv(31), 32'h104);
    alu(5'd6, 32'h22, 1'b1, 32'h33, 32'h108);
    has_flushed_in = 1'b1;
    tick();
    chk("r6", rv(6), 32'h22);
    chk("r7_upper", rv(7), 32'h33);
    chk("pc_seq1", rv(31), 32'h108);
    chk("flush_out", {31'b0, has_flushed_out}, 32'd1);
    alu(5'd0, 32'h44, 1'b0, '0, 32'h10c);
    tick();
    chk("r0_zero", rv(0), 32'h0);
    chk("r5_kept", rv(5), 32'h11);
    chk("pc_seq2", rv(31), 32'h10c);
    chk("flush_clr", {31'b0, has_flushed_out}, 32'd0);
    alu(5'd2, 32'h1000, 1'b0, '0, 32'h110);
    tick();

    // Single store with a slow memory
    st(5'd2, 32'h8, 32'hAB, 4'h0);
    #1;
    chk("st_hold", {31'b0, hold}, 32'd0);
    chk("st_fb", {31'b0, fb_valid}, 32'd0);
    sb.push_back('{a: 32'h1008, d: 32'hAB});
    tick();
    clr();
    chk("st_ae", {31'b0, address_enable}, 32'd1);
    chk("st_nempty", {31'b0, sq_empty}, 32'd0);
    tick(); tick();
    chk("st_addr_stable", address, 32'h1008);
    take("st1");
    chk("st_empty_after", {31'b0, sq_empty}, 32'd1);

    // Fill the queue, then push while popping at full
    for (int i = 0; i < 4; i++) begin
      st(5'd2, 32'(i * 4), 32'(32'h100 + i), 4'h0);
      #1;
      chk("fill_hold", {31'b0, hold}, 32'd0);
      sb.push_back('{a: 32'(32'h1000 + i * 4), d: 32'(32'h100 + i)});
      tick();
    end
    st(5'd2, 32'h10, 32'h104, 4'h0);
    #1;
    chk("full_hold", {31'b0, hold}, 32'd1);
    tick();
    chk("full_hold_still", {31'b0, hold}, 32'd1);
    data_valid = 1'b1;
    #1;
    chk("full_pop_nohold", {31'b0, hold}, 32'd0);
    e = sb.pop_front();
    chk("full_pop_addr", address, e.a);
    chk("full_pop_data", data, e.d);
    sb.push_back('{a: 32'h1010, d: 32'h104});
    tick();
    data_valid = 1'b0;
    #1;
    chk("count_kept_full", {31'b0, hold}, 32'd1);
    clr();
    for (int i = 0; i < 3; i++) take("drain");
    chk("drain_nempty", {31'b0, sq_empty}, 32'd0);
    take("drain_last");
    chk("drain_empty", {31'b0, sq_empty}, 32'd1);

    // PC write, then flags merged by a store
    alu(5'd31, 32'h200, 1'b0, '0, 32'h114);
    tick();
    chk("pc_write", rv(31), 32'h200);
    clr();
    next_pc = 32'h300;
    tick();
    chk("pc_idle_seq", rv(31), 32'h300);
    st(5'd2, 32'h20, 32'h55, 4'hA);
    sb.push_back('{a: 32'h1020, d: 32'h55});
    tick();
    clr();
    chk("flags_merge", rv(30), 32'h5000_0000);
    chk("flags_r2", rv(2), 32'h1000);
    chk("flags_r7", rv(7), 32'h33);
    chk("flags_r5", rv(5), 32'h11);
    take("flag_st");

    // Reset while stores are queued
    for (int i = 0; i < 3; i++) begin
      st(5'd2, 32'(32'h40 + i * 4), 32'(i), 4'h0);
      tick();
    end
    clr();
    chk("pre_rst_ae", {31'b0, address_enable}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ae", {31'b0, address_enable}, 32'd0);
    chk("rst_empty", {31'b0, sq_empty}, 32'd1);
    chk("rst_regs_r2", rv(2), 32'h0);
    checks++;
    assert (output_registers === '0) else begin
      errors++;
      $error("FAIL rst_regs observed=%0h expected=0", output_registers[W-1:0]);
    end
    tick();
    reset_n = 1'b1;
    tick();

    // Two stores to one address
    st(5'd0, 32'h40, 32'h1, 4'h0);
    sb.push_back('{a: 32'h40, d: 32'h1});
    tick();
    st(5'd0, 32'h40, 32'h2, 4'h0);
    #1;
    chk("comb_hold", {31'b0, hold}, 32'd0);
`ifdef WRITE_BUFFERED_COMBINE_EN
    sb[sb.size() - 1].d = 32'h2;
`else
    sb.push_back('{a: 32'h40, d: 32'h2});
`endif
    tick();
    clr();
    take("comb1");
`ifndef WRITE_BUFFERED_COMBINE_EN
    take("comb2");
`endif
    chk("comb_empty", {31'b0, sq_empty}, 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffered.md
Name: write_buffered

Overview:
- Parametrised successor of the write-back stage.
- Commits register results to the register file and publishes feedback for forwarding, as before.
- Memory stores are posted into a DEPTH-entry store queue, so the pipeline no longer stalls per store; it holds only when the queue is full.
- The queue drains to the memory port under an address_enable/data_valid handshake; an empty flag lets fence logic wait for drain.

Parameters:
- W, 32, register/data width in bits
- NR, 32, number of architectural registers
- PC_IDX, NR-1, register index of the program counter
- FLAGS_IDX, NR-2, register index of the flags register
- FLAG_BITS, 4, width of the flags field merged into the flags register at bits [W-2 -: FLAG_BITS]
- DEPTH, 4, store queue entries (power of two, >=2)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- is_valid  in  1  incoming instruction is valid
- hold  out  1  stall upstream stages
- destination_register  in  $clog2(NR)  target register, or base register for a store
- destination_value  in  W  result value, or store data
- has_upper_value  in  1  result also writes destination_register+1
- upper_value  in  W  value for destination_register+1
- is_writing_memory  in  1  instruction is a store
- adjustment_value  in  W  store address offset
- flags  in  FLAG_BITS  new flags
- pc  in  W  PC of the instruction when fetched
- next_pc  in  W  sequential next PC
- has_flushed_in  in  1  flush marker from execute
- has_flushed_out  out  1  registered flush marker
- input_registers  in  NR*W  current register file (flattened)
- output_registers  out  NR*W  next register file (flattened)
- address_enable  out  1  memory write request
- address  out  W  memory write address (queue head)
- data  out  W  memory write data (queue head)
- data_valid  in  1  memory accepted the head write
- sq_empty  out  1  store queue empty
- fb_valid, fb_index, fb_value, fb_upper_value, fb_has_upper  out  1/$clog2(NR)/W/W/1  feedback to decode

Behaviour:
- Reset (async, reset_n=0):
  - output_registers = 0; has_flushed_out = 0.
  - Queue pointers and count = 0; sq_empty = 1; address_enable = 0; hold = 0.
- Accept = is_valid && !hold.
- Register commit, for non-stores, registered at the clock edge:
  - Register 0 is always 0.
  - Register destination_register gets destination_value.
  - If has_upper_value, register destination_register+1 gets upper_value (index wraps modulo NR; the write is dropped if the wrapped index is 0).
  - Flags register: bit W-1 is kept, bits [W-2 -: FLAG_BITS] take flags, the rest are kept; the whole register is overwritten if it is the destination.
- Stores: only the flags merge is committed to the register file.
- PC update, every cycle: if accepted, not a store, and destination_register==PC_IDX, PC takes destination_value; otherwise PC takes next_pc.
- has_flushed_out <= accept ? has_flushed_in : 0.
- Enqueue, on an accepted store:
  - Entry address = base + adjustment_value (mod 2^W).
  - base = the current-cycle view of destination_register: pc if it is PC_IDX, 0 if it is 0, otherwise input_registers.
  - Entry data = destination_value.
- Drain:
  - address_enable = !sq_empty.
  - address/data are the head entry, held stable until data_valid.
  - data_valid while address_enable pops the head at the clock edge; data_valid while empty is ignored.
- hold = reset_n && is_valid && is_writing_memory && full && !(data_valid && address_enable).
  - A pop and a push in the same cycle with the queue full is permitted; count is unchanged.
- Full (count==DEPTH) and empty are computed from count; pointers wrap modulo DEPTH.
- Feedback (combinational):
  - fb_valid = is_valid && !is_writing_memory; fb_index = destination_register; fb_value = destination_value; fb_upper_value = upper_value; fb_has_upper = has_upper_value.
- Reset mid-drain discards all queued stores; address_enable drops asynchronously.
- Latency: register commit 1 cycle; a store reaches address_enable 1 cycle after accept.

Optional Feature:
- Macro: WRITE_BUFFERED_COMBINE_EN.
- Defined:
  - An accepted store whose computed address equals the tail (newest) entry's address, with that entry not being presented under data_valid this cycle, overwrites the tail data instead of enqueueing.
  - A combined store does not increase count and does not assert hold even when full.
- Undefined: every store enqueues a new entry.

Test Plan:
- Reset, then 3 ALU writes r5=0x11, r6=0x22 with has_upper (r7=0x33), r0=0x44 -> r5=0x11, r6=0x22, r7=0x33, r0 stays 0; PC follows next_pc.
- Store base r2=0x1000, adj=8, data=0xAB, memory slow (data_valid after 3 cycles) -> address_enable next cycle with address=0x1008, data=0xAB, no hold; sq_empty returns to 1 after the pop.
- DEPTH=4, 5 back-to-back stores, data_valid=0 -> hold asserted on the 5th only; raising data_valid for 1 cycle accepts the 5th in the same cycle while count stays 4.
- Write to PC_IDX with 0x200 -> PC=0x200 next cycle; flags=0xA on a store -> flags bits updated, other registers unchanged.
- Assert reset_n=0 with 3 queued stores -> address_enable=0 immediately, sq_empty=1, output_registers=0.
- WRITE_BUFFERED_COMBINE_EN: two stores to 0x40 (0x1, then 0x2) with data_valid=0 -> a single entry, data 0x2; without the macro -> two entries, drained in order 0x1 then 0x2.
